// File: rtl/intr_sequencer.sv
// Multi-source interrupt sequencer: edge-latched requests, fixed-priority arbitration,
// bounded nesting stack, and fetch-stage injection/vectoring handshake.
module intr_sequencer #(
  parameter int               N_IRQ      = 4,
  parameter int               NEST_DEPTH = 2,
  parameter int               VEC_W      = 8,
  parameter logic [VEC_W-1:0] VEC_BASE   = 8'h01,
  localparam int              DW         = $clog2(NEST_DEPTH + 1),
  localparam int              IDW        = $clog2(N_IRQ + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             en_we,
  input  logic [N_IRQ-1:0] en_wdata,
  input  logic [3:0]       opcode,
  input  logic [1:0]       ra,
  input  logic             instr_valid,
  input  logic             stall_in,
  input  logic             branch_taken,
  output logic             sf1,
  output logic             pc_en,
  output logic             pc_load,
  output logic [VEC_W-1:0] vec_addr,
  output logic [N_IRQ-1:0] int_ack,
  output logic             int_active,
  output logic [DW-1:0]    depth,
  output logic             rti_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, INJECT = 2'd1, VECTOR = 2'd2} state_t;

  state_t           state_r, state_next_s;
  logic [N_IRQ-1:0] irq_q_r, pend_r, en_r;
  logic [N_IRQ-1:0] edge_s, elig_s, ack_s, pend_next_s;
  logic [IDW-1:0]   stk_r [NEST_DEPTH];
  logic [IDW-1:0]   w_r, win_s, top_s;
  logic             win_found_s, accept_s, rti_s, pop_s, push_s;
  logic [DW-1:0]    depth_r, slot_s, depth_next_s;

  assign edge_s       = irq & ~irq_q_r;
  assign elig_s       = pend_r & en_r;
  assign win_found_s  = |elig_s;
  assign rti_s        = instr_valid && (opcode == 4'd11) && (ra == 2'd3);
  assign pop_s        = rti_s && (depth_r != {DW{1'b0}});
  assign push_s       = (state_r == INJECT) && !stall_in;
  // A simultaneous pop frees the current top slot, so the new entry replaces it.
  assign slot_s       = pop_s ? (depth_r - DW'(1)) : depth_r;
  assign depth_next_s = depth_r + DW'(push_s) - DW'(pop_s);
  assign accept_s     = win_found_s && (depth_r < DW'(NEST_DEPTH)) && (win_s < top_s);
  assign pend_next_s  = (pend_r & ~ack_s) | edge_s;

  assign sf1     = (state_r == INJECT);
  assign pc_en   = (state_r != INJECT);
  assign pc_load = (state_r == VECTOR);
  assign depth   = depth_r;

  // Priority winner, stack-top id and acknowledge decode
  always_comb begin
    win_s = {IDW{1'b0}};
    top_s = IDW'(N_IRQ);
    ack_s = {N_IRQ{1'b0}};
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      win_s = elig_s[i] ? IDW'(i) : win_s;
    end
    for (int i = 0; i < NEST_DEPTH; i++) begin
      top_s = (depth_r == DW'(i + 1)) ? stk_r[i] : top_s;
    end
    for (int i = 0; i < N_IRQ; i++) begin
      ack_s[i] = push_s && (w_r == IDW'(i));
    end
  end

  // Next-state logic; an RTI in IDLE takes precedence over a new injection
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !stall_in && !branch_taken && !rti_s) state_next_s = INJECT;
        else                                                   state_next_s = IDLE;
      end
      INJECT: begin
        if (!stall_in) state_next_s = VECTOR;
        else           state_next_s = INJECT;
      end
      VECTOR:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, request latching, enables and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      irq_q_r    <= {N_IRQ{1'b0}};
      pend_r     <= {N_IRQ{1'b0}};
      en_r       <= {N_IRQ{1'b0}};
      w_r        <= {IDW{1'b0}};
      depth_r    <= {DW{1'b0}};
      int_ack    <= {N_IRQ{1'b0}};
      int_active <= 1'b0;
      vec_addr   <= {VEC_W{1'b0}};
      rti_err    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      irq_q_r    <= irq;
      pend_r     <= pend_next_s;
      if (en_we) en_r <= en_wdata;
      if ((state_r == IDLE) && (state_next_s == INJECT)) w_r <= win_s;
      if (push_s) vec_addr <= VEC_BASE + VEC_W'(w_r);
      depth_r    <= depth_next_s;
      int_active <= (depth_next_s != {DW{1'b0}});
      int_ack    <= ack_s;
      rti_err    <= rti_s && (depth_r == {DW{1'b0}});
    end
  end

  // Nesting stack of accepted line ids
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NEST_DEPTH; i++) stk_r[i] <= {IDW{1'b0}};
    end else begin
      for (int i = 0; i < NEST_DEPTH; i++) begin
        if (push_s && (slot_s == DW'(i))) stk_r[i] <= w_r;
      end
    end
  end

endmodule

// File: tb/tb_intr_sequencer.sv
// Self-checking bench for intr_sequencer: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_intr_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq, en_wdata, opcode, int_ack;
  logic [1:0] ra, depth;
  logic       en_we, instr_valid, stall_in, branch_taken;
  logic       sf1, pc_en, pc_load, int_active, rti_err;
  logic [7:0] vec_addr;
  int         checks = 0;
  int         errors = 0;

  // reference model state
  logic [3:0] m_pend, m_en, m_prev, e_ack;
  logic [7:0] e_vec;
  logic       e_err;
  int         m_stk[$];
  int         m_phase, m_w;

  intr_sequencer dut (
    .clk(clk), .rst(rst), .irq(irq), .en_we(en_we), .en_wdata(en_wdata),
    .opcode(opcode), .ra(ra), .instr_valid(instr_valid), .stall_in(stall_in),
    .branch_taken(branch_taken), .sf1(sf1), .pc_en(pc_en), .pc_load(pc_load),
    .vec_addr(vec_addr), .int_ack(int_ack), .int_active(int_active),
    .depth(depth), .rti_err(rti_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = 4'b0; m_en = 4'b0; m_prev = 4'b0; e_ack = 4'b0; e_vec = 8'h00; e_err = 1'b0;
    m_stk.delete(); m_phase = 0; m_w = 0;
  endtask

  // One clock of the specification's rules, using the inputs present at the edge
  task automatic model_step();
    bit rti; int d, top, win; logic [3:0] edg;
    rti = instr_valid && (opcode == 4'd11) && (ra == 2'd3);
    d = m_stk.size();
    top = (d == 0) ? 4 : m_stk[d-1];
    win = -1;
    for (int i = 3; i >= 0; i--) if (m_pend[i] && m_en[i]) win = i;
    e_err = rti && (d == 0);
    e_ack = 4'b0;
    edg = irq & ~m_prev;
    if (m_phase == 1 && !stall_in) begin
      e_ack[m_w] = 1'b1;
      e_vec = 8'(1 + m_w);
    end
    m_pend = (m_pend & ~e_ack) | edg;
    m_prev = irq;
    if (rti && d > 0) void'(m_stk.pop_back());
    if (e_ack != 4'b0) m_stk.push_back(m_w);
    case (m_phase)
      0: if (win >= 0 && d < 2 && win < top && !stall_in && !branch_taken && !rti) begin
           m_phase = 1; m_w = win;
         end
      1: if (!stall_in) m_phase = 2;
      default: m_phase = 0;
    endcase
    if (en_we) m_en = en_wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] m);
    irq = m; tick(); irq = 4'b0;
  endtask

  task automatic set_en(input logic [3:0] m);
    en_we = 1'b1; en_wdata = m; tick(); en_we = 1'b0;
  endtask

  task automatic rti(input int n);
    instr_valid = 1'b1; opcode = 4'd11; ra = 2'd3;
    repeat (n) tick();
    instr_valid = 1'b0; opcode = 4'd0; ra = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0; irq = 4'b0; en_we = 1'b0; en_wdata = 4'b0; opcode = 4'd0; ra = 2'd0;
    instr_valid = 1'b0; stall_in = 1'b0; branch_taken = 1'b0;
    model_reset();
    #12;
    checks++; if (sf1 !== 1'b0)       begin errors++; $display("FAIL rst_sf1 got %b exp 0", sf1); end
    checks++; if (pc_en !== 1'b1)     begin errors++; $display("FAIL rst_pc_en got %b exp 1", pc_en); end
    checks++; if (pc_load !== 1'b0)   begin errors++; $display("FAIL rst_pc_load got %b exp 0", pc_load); end
    checks++; if (vec_addr !== 8'h00) begin errors++; $display("FAIL rst_vec got %h exp 00", vec_addr); end
    checks++; if (int_ack !== 4'b0)   begin errors++; $display("FAIL rst_ack got %b exp 0000", int_ack); end
    checks++; if (depth !== 2'd0 || int_active !== 1'b0 || rti_err !== 1'b0)
      begin errors++; $display("FAIL rst_depth got %0d/%b/%b exp 0/0/0", depth, int_active, rti_err); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single();
    set_en(4'b0100);
    irq = 4'b0100; tick(); irq = 4'b0;
    checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL t1_sf1_early got %b exp 0", sf1); end
    tick();
    checks++; if (sf1 !== 1'b1 || pc_en !== 1'b0) begin errors++; $display("FAIL t1_inject got sf1=%b pc_en=%b exp 1/0", sf1, pc_en); end
    tick();
    checks++; if (pc_load !== 1'b1 || vec_addr !== 8'h03) begin errors++; $display("FAIL t1_vector got %b/%h exp 1/03", pc_load, vec_addr); end
    checks++; if (int_ack !== 4'b0100 || depth !== 2'd1) begin errors++; $display("FAIL t1_ack got %b/%0d exp 0100/1", int_ack, depth); end
    tick();
    checks++; if (int_ack !== 4'b0 || pc_load !== 1'b0 || int_active !== 1'b1)
      begin errors++; $display("FAIL t1_after got %b/%b/%b exp 0000/0/1", int_ack, pc_load, int_active); end
    rti(1);
    checks++; if (depth !== 2'd0 || int_active !== 1'b0) begin errors++; $display("FAIL t1_rti got %0d/%b exp 0/0", depth, int_active); end
  endtask

  task automatic test_priority();
    set_en(4'b1111);
    pulse(4'b1010); tick(); tick();
    checks++; if (vec_addr !== 8'h02 || int_ack !== 4'b0010) begin errors++; $display("FAIL t2_first got %h/%b exp 02/0010", vec_addr, int_ack); end
    tick(); tick();
    checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL t2_hold got %b exp 0", sf1); end
    rti(1);
    checks++; if (depth !== 2'd0 || sf1 !== 1'b0) begin errors++; $display("FAIL t2_pop got %0d/%b exp 0/0", depth, sf1); end
    tick();
    checks++; if (sf1 !== 1'b1) begin errors++; $display("FAIL t2_second_inj got %b exp 1", sf1); end
    tick();
    checks++; if (vec_addr !== 8'h04 || int_ack !== 4'b1000) begin errors++; $display("FAIL t2_second got %h/%b exp 04/1000", vec_addr, int_ack); end
    tick(); rti(1);
  endtask

  task automatic test_nesting();
    pulse(4'b0100); tick(); tick(); tick();
    pulse(4'b0001); tick();
    checks++; if (sf1 !== 1'b1) begin errors++; $display("FAIL t3_nest_inj got %b exp 1", sf1); end
    tick();
    checks++; if (vec_addr !== 8'h01 || depth !== 2'd2) begin errors++; $display("FAIL t3_nest got %h/%0d exp 01/2", vec_addr, depth); end
    tick();
    pulse(4'b0010); tick();
    checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL t3_full got %b exp 0", sf1); end
    tick();
    checks++; if (sf1 !== 1'b0 || depth !== 2'd2) begin errors++; $display("FAIL t3_full2 got %b/%0d exp 0/2", sf1, depth); end
    rti(2);
    checks++; if (depth !== 2'd0 || sf1 !== 1'b0) begin errors++; $display("FAIL t3_pops got %0d/%b exp 0/0", depth, sf1); end
    tick();
    checks++; if (sf1 !== 1'b1) begin errors++; $display("FAIL t3_late_inj got %b exp 1", sf1); end
    tick();
    checks++; if (vec_addr !== 8'h02 || depth !== 2'd1) begin errors++; $display("FAIL t3_late got %h/%0d exp 02/1", vec_addr, depth); end
    tick(); rti(1);
  endtask

  task automatic test_blocking();
    pulse(4'b1000); tick();
    stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (sf1 !== 1'b1 || int_ack !== 4'b0) begin errors++; $display("FAIL t4_stall%0d got %b/%b exp 1/0000", k, sf1, int_ack); end
    end
    stall_in = 1'b0; tick();
    checks++; if (pc_load !== 1'b1 || int_ack !== 4'b1000) begin errors++; $display("FAIL t4_release got %b/%b exp 1/1000", pc_load, int_ack); end
    tick(); rti(1);
    pulse(4'b1000);
    branch_taken = 1'b1; tick(); branch_taken = 1'b0;
    checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL t4_branch got %b exp 0", sf1); end
    tick();
    checks++; if (sf1 !== 1'b1) begin errors++; $display("FAIL t4_branch_late got %b exp 1", sf1); end
    tick();
    checks++; if (vec_addr !== 8'h04) begin errors++; $display("FAIL t4_vec got %h exp 04", vec_addr); end
    tick(); rti(1);
  endtask

  task automatic test_rti_edge();
    rti(1);
    checks++; if (rti_err !== 1'b1 || depth !== 2'd0) begin errors++; $display("FAIL t5_err got %b/%0d exp 1/0", rti_err, depth); end
    tick();
    checks++; if (rti_err !== 1'b0) begin errors++; $display("FAIL t5_err_pulse got %b exp 0", rti_err); end
    pulse(4'b1000); tick(); tick(); tick();
    pulse(4'b0010);
    rti(1);
    checks++; if (sf1 !== 1'b0 || depth !== 2'd0) begin errors++; $display("FAIL t5_popfirst got %b/%0d exp 0/0", sf1, depth); end
    tick();
    checks++; if (sf1 !== 1'b1) begin errors++; $display("FAIL t5_inj got %b exp 1", sf1); end
    tick();
    checks++; if (vec_addr !== 8'h02 || depth !== 2'd1) begin errors++; $display("FAIL t5_vec got %h/%0d exp 02/1", vec_addr, depth); end
    tick(); rti(1);
  endtask

  task automatic test_reset_mid();
    pulse(4'b1001); tick(); tick();
    checks++; if (pc_load !== 1'b1 || vec_addr !== 8'h01) begin errors++; $display("FAIL t6_vector got %b/%h exp 1/01", pc_load, vec_addr); end
    #1 rst = 1'b0;
    #1;
    checks++; if (pc_load !== 1'b0 || depth !== 2'd0 || vec_addr !== 8'h00 || int_ack !== 4'b0)
      begin errors++; $display("FAIL t6_async got %b/%0d/%h/%b exp 0/0/00/0000", pc_load, depth, vec_addr, int_ack); end
    model_reset();
    @(negedge clk); rst = 1'b1;
    set_en(4'b1000); tick();
    checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL t6_pend_clear got %b exp 0", sf1); end
    pulse(4'b0010); tick();
    checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL t6_masked got %b exp 0", sf1); end
    set_en(4'b1010); tick();
    checks++; if (sf1 !== 1'b1) begin errors++; $display("FAIL t6_unmask_inj got %b exp 1", sf1); end
    tick();
    checks++; if (vec_addr !== 8'h02 || int_ack !== 4'b0010) begin errors++; $display("FAIL t6_unmask got %h/%b exp 02/0010", vec_addr, int_ack); end
    tick(); rti(1);
  endtask

  task automatic test_random();
    rst = 1'b0; #2; model_reset();
    @(negedge clk); rst = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      irq          = irq ^ (4'($urandom) & 4'($urandom));
      en_we        = ($urandom_range(0, 15) == 0);
      en_wdata     = 4'($urandom);
      instr_valid  = ($urandom_range(0, 3) != 0);
      opcode       = ($urandom_range(0, 4) == 0) ? 4'd11 : 4'($urandom);
      ra           = ($urandom_range(0, 1) == 0) ? 2'd3 : 2'($urandom);
      stall_in     = ($urandom_range(0, 9) < 3);
      branch_taken = ($urandom_range(0, 9) < 2);
      tick();
      checks++; if (sf1 !== (m_phase == 1))     begin errors++; $display("FAIL rnd_sf1 cyc %0d got %b exp %b", n, sf1, m_phase == 1); end
      checks++; if (pc_en !== (m_phase != 1))   begin errors++; $display("FAIL rnd_pc_en cyc %0d got %b exp %b", n, pc_en, m_phase != 1); end
      checks++; if (pc_load !== (m_phase == 2)) begin errors++; $display("FAIL rnd_pc_load cyc %0d got %b exp %b", n, pc_load, m_phase == 2); end
      checks++; if (int_ack !== e_ack)          begin errors++; $display("FAIL rnd_ack cyc %0d got %b exp %b", n, int_ack, e_ack); end
      checks++; if (vec_addr !== e_vec)         begin errors++; $display("FAIL rnd_vec cyc %0d got %h exp %h", n, vec_addr, e_vec); end
      checks++; if (depth !== 2'(m_stk.size())) begin errors++; $display("FAIL rnd_depth cyc %0d got %0d exp %0d", n, depth, m_stk.size()); end
      checks++; if (int_active !== (m_stk.size() != 0)) begin errors++; $display("FAIL rnd_active cyc %0d got %b", n, int_active); end
      checks++; if (rti_err !== e_err)          begin errors++; $display("FAIL rnd_rti_err cyc %0d got %b exp %b", n, rti_err, e_err); end
    end
    irq = 4'b0; en_we = 1'b0; instr_valid = 1'b0; stall_in = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_nesting();
    test_blocking();
    test_rti_edge();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
